// File: rtl/pc_jump_unit.sv
// Hack-CPU program counter stage: jump evaluation, next-PC select, halt-loop
// detection with resume, and a retired-instruction counter.
module pc_jump_unit #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_ADDR  = '0,
  parameter bit               HALT_DETECT = 1'b1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             is_c_i,
  input  logic [2:0]       jump_i,
  input  logic             zr_i,
  input  logic             ng_i,
  input  logic [WIDTH-1:0] a_reg_i,
  input  logic             resume_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             taken_o,
  output logic             halted_o,
  output logic [WIDTH-1:0] retired_o
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] retired_q, retired_d;
  logic             taken_q, taken_d;

  logic             cond;
  logic             halt_hit;
  logic [WIDTH-1:0] pc_inc;

  // jump bits are j1=lt, j2=eq, j3=gt; zr=ng=1 simply falls through the formula
  assign cond = is_c_i & ((jump_i[2] & ng_i) |
                          (jump_i[1] & zr_i) |
                          (jump_i[0] & ~ng_i & ~zr_i));

  assign pc_inc   = pc_q + WIDTH'(1);
  assign halt_hit = HALT_DETECT && cond && (jump_i == 3'b111) && (a_reg_i == pc_q);

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  if (en_i && halt_hit) state_d = ST_HALT;
      ST_HALT: if (resume_i)         state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Datapath next values; HALT ignores en, and resume steps past the self-jump
  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    taken_d   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (en_i) begin
          pc_d      = cond ? a_reg_i : pc_inc;
          taken_d   = cond;
          retired_d = retired_q + WIDTH'(1);
        end
      end
      ST_HALT: begin
        if (resume_i) pc_d = pc_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q      <= RESET_ADDR;
      retired_q <= '0;
      taken_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  // Output logic: every output comes straight from a flop
  always_comb begin
    pc_o      = pc_q;
    retired_o = retired_q;
    taken_o   = taken_q;
    halted_o  = (state_q == ST_HALT);
  end

endmodule

// File: tb/tb_pc_jump_unit.sv
// Directed table-driven bench for pc_jump_unit plus hand sequences for
// stall and asynchronous reset.
module tb_pc_jump_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        en, is_c, zr, ng, resume;
  logic [2:0]  jump;
  logic [15:0] a_reg;
  logic [15:0] pc, retired;
  logic        taken, halted;

  int checks = 0;
  int fails  = 0;

  pc_jump_unit #(.WIDTH(16), .RESET_ADDR(16'h0000), .HALT_DETECT(1'b1)) dut (
    .clock_i  (clock),
    .reset_i  (reset),
    .en_i     (en),
    .is_c_i   (is_c),
    .jump_i   (jump),
    .zr_i     (zr),
    .ng_i     (ng),
    .a_reg_i  (a_reg),
    .resume_i (resume),
    .pc_o     (pc),
    .taken_o  (taken),
    .halted_o (halted),
    .retired_o(retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en, is_c;
    logic [2:0]  jump;
    logic        zr, ng;
    logic [15:0] a_reg;
    logic        resume;
    logic [15:0] exp_pc;
    logic        exp_taken, exp_halted;
    logic [15:0] exp_retired;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_pc, input logic e_t,
                           input logic e_h, input logic [15:0] e_r);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".taken"}, {15'd0, taken}, {15'd0, e_t});
    check({tag, ".halted"}, {15'd0, halted}, {15'd0, e_h});
    check({tag, ".retired"}, retired, e_r);
  endtask

  task automatic drive(input logic e, input logic c, input logic [2:0] j, input logic z,
                       input logic n, input logic [15:0] a, input logic r);
    en = e; is_c = c; jump = j; zr = z; ng = n; a_reg = a; resume = r;
  endtask

  initial begin
    //            en  c  jump    zr ng a_reg     res  pc        t  h  retired
    vecs[0]  = '{1, 0, 3'b000, 0, 0, 16'h0000, 0, 16'h0001, 0, 0, 16'd1};
    vecs[1]  = '{1, 0, 3'b000, 0, 0, 16'h0000, 0, 16'h0002, 0, 0, 16'd2};
    vecs[2]  = '{1, 0, 3'b000, 0, 0, 16'h0000, 0, 16'h0003, 0, 0, 16'd3};
    vecs[3]  = '{1, 1, 3'b100, 0, 1, 16'h0005, 0, 16'h0005, 1, 0, 16'd4};  // JLT taken
    vecs[4]  = '{1, 1, 3'b001, 1, 0, 16'h0005, 0, 16'h0006, 0, 0, 16'd5};  // JGT not taken
    vecs[5]  = '{1, 1, 3'b010, 1, 0, 16'h0005, 0, 16'h0005, 1, 0, 16'd6};  // JEQ taken
    vecs[6]  = '{0, 0, 3'b000, 0, 0, 16'h0000, 0, 16'h0005, 0, 0, 16'd6};
    vecs[7]  = '{0, 1, 3'b111, 0, 0, 16'h0009, 0, 16'h0005, 0, 0, 16'd6};
    vecs[8]  = '{1, 0, 3'b000, 0, 0, 16'h0000, 0, 16'h0006, 0, 0, 16'd7};
    vecs[9]  = '{1, 1, 3'b010, 1, 0, 16'h0006, 0, 16'h0006, 1, 0, 16'd8};  // conditional self-jump
    vecs[10] = '{1, 1, 3'b111, 0, 0, 16'h0010, 0, 16'h0010, 1, 0, 16'd9};
    vecs[11] = '{1, 1, 3'b111, 0, 0, 16'h0010, 0, 16'h0010, 1, 1, 16'd10}; // halt loop
    vecs[12] = '{1, 0, 3'b000, 0, 0, 16'h0000, 0, 16'h0010, 0, 1, 16'd10};
    vecs[13] = '{0, 0, 3'b000, 0, 0, 16'h0000, 0, 16'h0010, 0, 1, 16'd10};
    vecs[14] = '{1, 1, 3'b111, 0, 0, 16'h0030, 1, 16'h0011, 0, 0, 16'd10}; // resume wins
    vecs[15] = '{1, 0, 3'b000, 0, 0, 16'h0000, 1, 16'h0012, 0, 0, 16'd11};
    vecs[16] = '{1, 1, 3'b111, 0, 0, 16'hFFFF, 0, 16'hFFFF, 1, 0, 16'd12};
    vecs[17] = '{1, 0, 3'b000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'd13}; // wrap
    vecs[18] = '{1, 1, 3'b001, 1, 1, 16'h0007, 0, 16'h0001, 0, 0, 16'd14};
    vecs[19] = '{1, 1, 3'b100, 1, 1, 16'h0007, 0, 16'h0007, 1, 0, 16'd15};
    vecs[20] = '{1, 0, 3'b111, 0, 1, 16'h0020, 0, 16'h0008, 0, 0, 16'd16};

    reset = 1'b1;
    drive(0, 0, 3'b000, 0, 0, 16'h0000, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_all("reset", 16'h0000, 0, 0, 16'd0);

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].en, vecs[i].is_c, vecs[i].jump, vecs[i].zr, vecs[i].ng,
            vecs[i].a_reg, vecs[i].resume);
      @(negedge clock);
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_taken,
                vecs[i].exp_halted, vecs[i].exp_retired);
      $display("vec%0d: pc=%h taken=%0d halted=%0d retired=%0d", i, pc, taken, halted, retired);
    end

    // Stall for four cycles mid-program, then continue from the same pc
    drive(1, 1, 3'b111, 0, 0, 16'h0042, 0);
    @(negedge clock);
    check_all("jmp42", 16'h0042, 1, 0, 16'd17);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 3'b111, 0, 0, 16'h0100, 0);
      @(negedge clock);
      check_all($sformatf("stall%0d", k), 16'h0042, 0, 0, 16'd17);
      $display("stall%0d: pc=%h retired=%0d", k, pc, retired);
    end
    drive(1, 0, 3'b000, 0, 0, 16'h0000, 0);
    @(negedge clock);
    check_all("after_stall", 16'h0043, 0, 0, 16'd18);

    // Jump back to 0x0042 and apply reset asynchronously, well before the next edge
    drive(1, 1, 3'b111, 0, 0, 16'h0042, 0);
    @(negedge clock);
    check_all("jmp42b", 16'h0042, 1, 0, 16'd19);
    drive(1, 0, 3'b000, 0, 0, 16'h0000, 0);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 16'h0000, 0, 0, 16'd0);
    $display("async_reset: pc=%h retired=%0d halted=%0d", pc, retired, halted);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_all("post_reset", 16'h0001, 0, 0, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
